// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and buffer entry type for the fetch sequencer.
package fetch_pkg;
    localparam int ADDR_W = 5;
    localparam int INST_W = 32;

    localparam logic [ADDR_W-1:0] PROG_BASE = 5'd1;  // word 0 holds the zero word
    localparam logic [ADDR_W-1:0] LAST_ADDR = 5'd31;
    localparam logic [INST_W-1:0] END_WORD  = 32'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer of {inst, pc} entries with flush; head is the oldest entry.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  entry_t           push_entry,
    output logic [CNT_W-1:0] count,
    output entry_t           head
);
    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy after this cycle's push/pop; the caller guarantees legality.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Storage and pointers; flush empties the buffer but leaves stale contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_entry;
                wr_q        <= ptr_inc(wr_q);
            end
            if (pop) rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign head  = mem_q[rd_q];
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the program from PROG_BASE into a small
// buffer, stops on the zero word or the last address, and honours redirects.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              push, pop, flush, handshake, room;
    logic [CNT_W-1:0]  count;
    entry_t            head;

    assign handshake = out_valid && out_ready;
    assign room      = (count < CNT_W'(DEPTH)) || handshake;

    // Next state, next fetch address and buffer control; redirect outranks everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = PROG_BASE;
                end
            end
            FETCH, HALT: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = redirect_addr;
                    state_d = FETCH;
                end else begin
                    pop = handshake;
                    if (state_q == FETCH && room) begin
                        if (imem_inst == END_WORD) begin
                            state_d = HALT;
                        end else begin
                            push = 1'b1;
                            if (pc_q == LAST_ADDR) state_d = HALT;
                            else                   pc_d    = pc_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and fetch address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= PROG_BASE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry ('{inst: imem_inst, pc: pc_q}),
        .count      (count),
        .head       (head)
    );

    assign imem_addr = pc_q;
    assign out_valid = (count != '0);
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;
    assign halted    = (state_q == HALT);
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, the number of fetch-buffer entries.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle pulse that begins fetching from the program base.
REQ-005 SHALL have port redirect_valid, input, 1 bit: branch or jump redirect request.
REQ-006 SHALL have port redirect_addr, input, 5 bits: word address to resume fetching from.
REQ-007 SHALL have port imem_addr, output, 5 bits: combinational-read address to the instruction memory.
REQ-008 SHALL have port imem_inst, input, 32 bits: instruction word returned combinationally for imem_addr.
REQ-009 SHALL have port out_valid, output, 1 bit: buffer head holds a valid instruction.
REQ-010 SHALL have port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-011 SHALL have port out_inst, output, 32 bits: head instruction.
REQ-012 SHALL have port out_pc, output, 5 bits: word address of the head instruction.
REQ-013 SHALL have port halted, output, 1 bit: high while in the HALT state.

Function
REQ-014 SHALL implement three states: IDLE, FETCH and HALT.
REQ-015 SHALL leave IDLE for FETCH on the edge where start=1; in IDLE, redirects are ignored and nothing is fetched.
REQ-016 SHALL drive imem_addr from the fetch_pc register; start SHALL load fetch_pc with the program base, 1 (address 0 holds a zero word).
REQ-017 SHALL, in FETCH, push {imem_inst, fetch_pc} and increment fetch_pc when the buffer has room: count<DEPTH, or count==DEPTH with a pop in the same cycle.
REQ-018 SHALL pop the head when out_valid && out_ready; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-019 SHALL give the following latency: start sampled at edge N; first fetch during cycle N+1; out_valid=1 with out_pc=1 during cycle N+2.
REQ-020 SHALL treat imem_inst==0 in FETCH as the end of the program: the word is not pushed, and the block enters HALT at that edge.
REQ-021 SHALL, when fetch_pc==31 is pushed, enter HALT; there is no wrap to 0.
REQ-022 SHALL let the buffer drain normally in HALT: out_valid stays asserted until the buffer is empty.
REQ-023 SHALL, on redirect_valid in FETCH or HALT, at the edge: flush the buffer (count=0), set fetch_pc=redirect_addr, discard any push or pop in that cycle, and enter or stay in FETCH.
REQ-024 SHALL give the following redirect latency: redirect at edge N; out_valid=0 during N+1; redirected instruction valid during N+2.
REQ-025 SHALL give redirect priority over start when both are high in FETCH or HALT; start outside IDLE SHALL be ignored.
REQ-026 SHALL, for redirect_addr==0, fetch the zero word, which halts per REQ-020.
REQ-027 SHALL hold out_inst and out_pc stable while out_valid && !out_ready.

Reset
REQ-028 SHALL, on reset, enter IDLE and set fetch_pc=1, so imem_addr=1.
REQ-029 SHALL, on reset, set count=0, out_valid=0, out_inst=0, out_pc=0 and halted=0.
REQ-030 SHALL let reset override start, redirect and handshake in the same cycle, including mid-fetch with a full buffer.

Structure
REQ-031 SHALL place in a shared package, fetch_pkg: ADDR_W=5, INST_W=32, PROG_BASE=1, LAST_ADDR=31, END_WORD=0, and the state enum {IDLE, FETCH, HALT}.
REQ-032 SHALL implement the buffer as sub-module fetch_fifo: DEPTH entries of {inst, pc}, with push, pop, flush, count, head outputs and synchronous reset.
REQ-033 SHALL keep the state machine and fetch_pc in fetch_sequencer; there are no combinational paths from out_ready to imem_addr.

Verification
REQ-034 SHALL cover: memory holds words 1..3 = A, B, C and word 4 = 0; pulse start with out_ready=1 -> outputs (A,1), (B,2), (C,3) on consecutive cycles from N+2, then halted=1 and out_valid=0.
REQ-035 SHALL cover: out_ready=0 for 5 cycles after start -> count saturates at 2, imem_addr holds 3, and head (A,1) stays stable; ready then drains A, B, C in order with no loss.
REQ-036 SHALL cover: redirect_valid with redirect_addr=10 while head is (B,2) -> out_valid=0 for the next cycle, then (mem[10],10); B is never delivered.
REQ-037 SHALL cover: a program filling words 1..31 with non-zero words -> word 31 is delivered and halted=1; imem_addr never wraps to 0.
REQ-038 SHALL cover: redirect in HALT to 5 -> halted=0 and (mem[5],5) is delivered; start and redirect in the same cycle -> the redirect target wins.
REQ-039 SHALL cover: reset asserted with a full buffer mid-FETCH -> next cycle is IDLE, out_valid=0, imem_addr=1, halted=0.
